// File: rtl/prbs_xnor_checker_if.sv
// Purpose : bundles the serial PRBS receive bus and the checker status outputs.
// Ports   : in_valid/in_bit/clr_err flow toward the checker; locked/err_pulse/err_count flow back.
// Latency : n/a (wires only); no backpressure, the checker accepts one bit every cycle.
interface prbs_xnor_checker_if #(
  parameter int ERR_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  // Source side: drives received bits and the error-count clear, observes status.
  modport master (
    output in_valid,
    output in_bit,
    output clr_err,
    input  locked,
    input  err_pulse,
    input  err_count
  );

  // Checker side.
  modport slave (
    input  in_valid,
    input  in_bit,
    input  clr_err,
    output locked,
    output err_pulse,
    output err_count
  );
endinterface

// File: rtl/prbs_xnor_checker.sv
// Purpose : self-synchronising checker for an XNOR-feedback PRBS bit stream; reports lock, counts errors.
// Latency : every output is registered and reflects the in_valid cycle one clock later.
// Backpressure : none; one bit accepted per cycle with in_valid high, idle cycles freeze all state.
// Ports   : clk, rst_n (synchronous, active low);
//           bus.in_valid/in_bit (received serial bit), bus.clr_err (clear err_count),
//           bus.locked (LOCKED state), bus.err_pulse (one pulse per error while locked),
//           bus.err_count (saturating error count while locked).
module prbs_xnor_checker #(
  parameter int WIDTH    = 7,
  parameter int TAP_A    = 7,
  parameter int TAP_B    = 6,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 8,
  parameter int ERR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prbs_xnor_checker_if.slave   bus
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  localparam logic [WIDTH-1:0]   ALL_ONES   = '1;
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;
  localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]  LOSS_MISS  = MISS_W'(LOSS_CNT);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;

  logic [WIDTH-1:0]     next_sr;
  logic                 exp_bit;
  logic                 mis;
  logic                 filled;
  logic                 lockup;

  // The received bit is always what enters the register, so a corrupted bit
  // re-appears at both taps later; that is why one flip costs three errors.
  assign next_sr = {sr_q[WIDTH-2:0], bus.in_bit};
  assign exp_bit = ~(sr_q[TAP_A-1] ^ sr_q[TAP_B-1]);
  assign mis     = (bus.in_bit != exp_bit);
  assign filled  = (fill_cnt_q == FILL_DONE);
  // All-ones is the XNOR lockup point; a legal stream never produces it, so
  // seeing it means the input is stuck or garbage, never a real match.
  assign lockup  = (next_sr == ALL_ONES);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (bus.in_valid) begin
      sr_d = next_sr;
      if (!filled) begin
        // Register contents are not yet all received bits: no prediction.
        fill_cnt_d = fill_cnt_q + 1'b1;
      end else begin
        case (state_q)
          SEARCH: begin
            if (mis || lockup) begin
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
            if (match_cnt_d == LOCK_MATCH) begin
              state_d     = LOCKED;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end
          end
          LOCKED: begin
            if (mis) begin
              err_pulse_d = 1'b1;
              if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
              end
              miss_cnt_d = miss_cnt_q + 1'b1;
            end else begin
              miss_cnt_d = '0;
            end
            // The error on the cycle that drops lock has already been counted above.
            if ((miss_cnt_d == LOSS_MISS) || lockup) begin
              state_d     = SEARCH;
              match_cnt_d = '0;
            end
          end
          default: begin
            state_d = SEARCH;
          end
        endcase
      end
    end

    // Clear beats a same-cycle increment and is honoured on idle cycles too.
    if (bus.clr_err) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_xnor_checker.sv
module tb_prbs_xnor_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  always #5 clk = ~clk;

  prbs_xnor_checker_if #(.ERR_W(16)) bus ();
  prbs_xnor_checker_if #(.ERR_W(4))  bus4 ();

  prbs_xnor_checker #(.ERR_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  prbs_xnor_checker #(.ERR_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [6:0] sr;
    int         fill;
    int         match;
    int         miss;
    bit         locked;
    bit         pulse;
    int         cnt;
  } model_t;

  typedef struct {
    bit l;
    bit p;
    int c;
  } exp_t;

  typedef struct {
    bit r;
    bit v;
    bit b;
    bit c;
    bit el;
    bit ep;
    int ec;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         sel = 0;
  model_t     mdl [2];
  exp_t       sb_q [$];
  logic [6:0] gen_sr;
  bit         act_l;
  bit         act_p;
  int         act_c;
  vec_t       vt [12];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour written from the stream's point of view: a history of
  // received bits and the lock/loss rules.
  function automatic model_t mstep(input model_t m, input bit r, input bit v,
                                   input bit b, input bit c, input int cmax);
    model_t n;
    bit     e;
    n = m;
    n.pulse = 1'b0;
    if (!r) begin
      n = '{default: 0};
      return n;
    end
    if (v) begin
      e = ~(m.sr[6] ^ m.sr[5]);
      n.sr = {m.sr[5:0], b};
      if (m.fill < 7) begin
        n.fill = m.fill + 1;
      end else if (!m.locked) begin
        n.match = ((b != e) || (n.sr == 7'h7f)) ? 0 : m.match + 1;
        if (n.match == 16) begin
          n.locked = 1'b1;
          n.miss   = 0;
          n.match  = 0;
        end
      end else begin
        if (b != e) begin
          n.pulse = 1'b1;
          n.cnt   = (m.cnt < cmax) ? m.cnt + 1 : m.cnt;
          n.miss  = m.miss + 1;
        end else begin
          n.miss = 0;
        end
        if ((n.miss == 8) || (n.sr == 7'h7f)) begin
          n.locked = 1'b0;
          n.match  = 0;
        end
      end
    end
    if (c) n.cnt = 0;
    return n;
  endfunction

  task automatic gen_bit(output bit b);
    b = ~(gen_sr[6] ^ gen_sr[5]);
    gen_sr = {gen_sr[5:0], b};
  endtask

  // One clock: drive at negedge, push the expectation, sample 1 ns after posedge.
  task automatic step(input bit r, input bit v, input bit b, input bit c);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      rst_n = r; bus.in_valid = v; bus.in_bit = b; bus.clr_err = c;
      bus4.in_valid = 1'b0; bus4.clr_err = 1'b0;
    end else begin
      rst4_n = r; bus4.in_valid = v; bus4.in_bit = b; bus4.clr_err = c;
      bus.in_valid = 1'b0; bus.clr_err = 1'b0;
    end
    mdl[sel] = mstep(mdl[sel], r, v, b, c, (sel == 0) ? 65535 : 15);
    e.l = mdl[sel].locked;
    e.p = mdl[sel].pulse;
    e.c = mdl[sel].cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      act_l = bus.locked; act_p = bus.err_pulse; act_c = int'(bus.err_count);
    end else begin
      act_l = bus4.locked; act_p = bus4.err_pulse; act_c = int'(bus4.err_count);
    end
    e = sb_q.pop_front();
    chk("sb_locked", int'(act_l), int'(e.l));
    chk("sb_err_pulse", int'(act_p), int'(e.p));
    chk("sb_err_count", act_c, e.c);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    gen_sr = '0;
  endtask

  initial begin
    bit b;
    int vi;
    int drop;
    int relock;
    int lock_seen;

    rst_n = 1'b0; rst4_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clr_err = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_bit = 1'b0; bus4.clr_err = 1'b0;
    mdl[0] = '{default: 0};
    mdl[1] = '{default: 0};
    gen_sr = '0;

    // Reset with toggling inputs, then the 7-bit fill window (no compare, no output).
    vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    for (int i = 0; i < 12; i++) begin
      step(vt[i].r, vt[i].v, vt[i].b, vt[i].c);
      chk($sformatf("vec%0d_locked", i), int'(act_l), int'(vt[i].el));
      chk($sformatf("vec%0d_pulse", i), int'(act_p), int'(vt[i].ep));
      chk($sformatf("vec%0d_count", i), act_c, vt[i].ec);
    end

    // Clean PRBS7 from seed 0: lock visible after valid bit 23, no errors in 508 bits.
    do_reset();
    for (vi = 1; vi <= 508; vi++) begin
      gen_bit(b);
      step(1'b1, 1'b1, b, 1'b0);
      chk($sformatf("clean_lock_idx%0d", vi), int'(act_l), (vi >= 23) ? 1 : 0);
    end
    chk("clean_err_count_508", act_c, 0);

    // Single inverted bit 100: pulses after bits 100, 106, 107; count 3; lock held.
    do_reset();
    for (vi = 1; vi <= 130; vi++) begin
      gen_bit(b);
      if (vi == 100) b = ~b;
      step(1'b1, 1'b1, b, 1'b0);
      if (vi >= 90)
        chk($sformatf("flip_pulse_idx%0d", vi), int'(act_p),
            (vi == 100 || vi == 106 || vi == 107) ? 1 : 0);
      if (vi >= 23)
        chk($sformatf("flip_locked_idx%0d", vi), int'(act_l), 1);
    end
    chk("flip_err_count", act_c, 3);

    // Stuck-at-1 after lock: lock lost within 7 bits and never regained.
    drop = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (!act_l && drop == 0) drop = k;
    end
    chk("stuck_drop_within_7", (drop >= 1 && drop <= 7) ? 1 : 0, 1);
    relock = 0;
    for (int k = 0; k < 200; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (act_l) relock++;
    end
    chk("stuck_no_relock", relock, 0);

    // Stuck-at-1 from reset: never locks.
    do_reset();
    lock_seen = 0;
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (act_l) lock_seen++;
    end
    chk("stuck_reset_never_lock", lock_seen, 0);

    // Random valid gaps: lock still at valid-bit index 23; garbage bits on idle cycles.
    do_reset();
    vi = 0;
    for (int k = 0; k < 200 && vi < 60; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        vi++;
        gen_bit(b);
        step(1'b1, 1'b1, b, 1'b0);
      end else begin
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk($sformatf("gap_lock_vidx%0d", vi), int'(act_l), (vi >= 23) ? 1 : 0);
    end

    // ERR_W=4 instance: saturation, clear priority, reset mid-lock.
    sel = 1;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      gen_bit(b);
      step(1'b1, 1'b1, b, 1'b0);
    end
    chk("w4_locked_before_errs", int'(act_l), 1);
    for (int f = 0; f < 20; f++) begin
      for (int j = 0; j < 20; j++) begin
        gen_bit(b);
        if (j == 0) b = ~b;
        step(1'b1, 1'b1, b, 1'b0);
      end
    end
    for (int k = 0; k < 40; k++) begin
      gen_bit(b);
      step(1'b1, 1'b1, b, 1'b0);
    end
    chk("w4_err_count_saturated", act_c, 15);
    chk("w4_locked_after_errs", int'(act_l), 1);
    gen_bit(b);
    step(1'b1, 1'b1, ~b, 1'b1);
    chk("w4_clr_beats_inc", act_c, 0);
    chk("w4_clr_pulse_still", int'(act_p), 1);
    for (int k = 0; k < 40; k++) begin
      gen_bit(b);
      step(1'b1, 1'b1, b, 1'b0);
    end
    chk("w4_locked_before_rst", int'(act_l), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("w4_rst_mid_lock_locked", int'(act_l), 0);
    chk("w4_rst_mid_lock_count", act_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
